// File: rtl/dma_pkg.sv
// Shared DMA package: FSM state encoding, AXI constants and burst-split limits
// used by both the read and write engines.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_AR_HANDSHAKE,
    ST_R_BURST,
    ST_DONE
  } dma_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int DMA_4K_BYTES        = 4096;
  localparam int DMA_MAX_BURST_BYTES = 1024;

endpackage

// File: rtl/dma_read_engine_if.sv
// AXI4 read-channel bundle (AR + R) between the DMA read engine and memory.
//   master : engine side (drives AR payload/valid and RREADY)
//   slave  : memory side (drives ARREADY and the R payload/valid)
interface dma_read_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/dma_burst_calc.sv
// Burst splitter: bytes = min(len_left, bytes to next 4KB page, 1024).
//   addr_i       : low 12 bits of the current byte address
//   len_left_i   : bytes still to transfer
//   bytes_o      : bytes in the next burst (multiple of 4, 4..1024)
//   len_minus1_o : AXI LEN field (beats-1) for that burst
module dma_burst_calc
  import dma_pkg::*;
(
  input  logic [11:0] addr_i,
  input  logic [31:0] len_left_i,
  output logic [10:0] bytes_o,
  output logic [7:0]  len_minus1_o
);
  logic [12:0] to_4k;
  logic [12:0] cap;
  logic [8:0]  words;

  // 1..4096 bytes remain in the current page; never zero since addr_i < 4096
  assign to_4k = 13'(DMA_4K_BYTES) - {1'b0, addr_i};
  assign cap   = (to_4k < 13'(DMA_MAX_BURST_BYTES)) ? to_4k : 13'(DMA_MAX_BURST_BYTES);

  // cap <= 1024, so whichever side wins fits in 11 bits
  assign bytes_o      = (len_left_i < {19'd0, cap}) ? len_left_i[10:0] : cap[10:0];
  assign words        = bytes_o[10:2];
  assign len_minus1_o = 8'(words - 9'd1);
endmodule

// File: rtl/dma_read_engine.sv
// DMA read engine (AXI4 MM2S): reads a contiguous region in bursts that never
// cross a 4KB page nor exceed 256 beats, one burst outstanding at a time, and
// streams each R beat straight into a downstream FIFO.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   i_start              : start pulse (honoured in IDLE only)
//   i_base_addr          : source byte address, 64B aligned
//   i_total_len          : bytes to read, nonzero multiple of 4
//   o_done               : one-cycle completion pulse
//   o_error              : sticky error flag
//   o_fifo_wdata/o_fifo_wen, i_fifo_full : FIFO write port
//   m_axi                : AXI read channels (master modport)
// Build option: define DMA_RD_RESP_CHECK_EN to flag non-OKAY RRESP and
// RLAST/beat-count disagreement in o_error.
module dma_read_engine
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [31:0]           i_total_len,
  output logic                  o_done,
  output logic                  o_error,
  output logic [DATA_WIDTH-1:0] o_fifo_wdata,
  output logic                  o_fifo_wen,
  input  logic                  i_fifo_full,
  dma_read_engine_if.master     m_axi
);
  dma_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           len_q;
  logic [7:0]            beat_q;
  logic [10:0]           bytes_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic                  error_q;

  logic [10:0] calc_bytes;
  logic [7:0]  calc_len_m1;
  logic        arg_bad;
  logic        ar_valid, r_ready, done;
  logic        r_hs, last_beat;

  dma_burst_calc u_calc (
    .addr_i       (addr_q[11:0]),
    .len_left_i   (len_q),
    .bytes_o      (calc_bytes),
    .len_minus1_o (calc_len_m1)
  );

  assign arg_bad   = (i_base_addr[5:0] != 6'd0) || (i_total_len[1:0] != 2'd0) ||
                     (i_total_len == 32'd0);
  assign r_hs      = m_axi.rvalid && r_ready;
  // The beat counter, not RLAST, decides where a burst ends
  assign last_beat = r_hs && (beat_q == arlen_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ar_valid = 1'b0;
    r_ready  = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE:         if (i_start && !arg_bad) state_d = ST_CALC;
      ST_CALC:         state_d = ST_AR_HANDSHAKE;
      ST_AR_HANDSHAKE: begin
        ar_valid = 1'b1;
        if (m_axi.arready) state_d = ST_R_BURST;
      end
      ST_R_BURST: begin
        // Full FIFO stalls the slave in the same cycle so no beat is dropped
        r_ready = !i_fifo_full;
        if (last_beat) state_d = (len_q == 32'(bytes_q)) ? ST_DONE : ST_CALC;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      bytes_q  <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (i_start) begin
          if (arg_bad) begin
            error_q <= 1'b1;
          end else begin
            error_q <= 1'b0;
            addr_q  <= i_base_addr;
            len_q   <= i_total_len;
          end
        end
        // AR payload is registered here so it holds steady while ARVALID waits
        ST_CALC: begin
          araddr_q <= addr_q;
          arlen_q  <= calc_len_m1;
          bytes_q  <= calc_bytes;
        end
        ST_AR_HANDSHAKE: if (m_axi.arready) beat_q <= '0;
        ST_R_BURST: if (r_hs) begin
          beat_q <= beat_q + 8'd1;
          if (beat_q == arlen_q) begin
            addr_q <= addr_q + ADDR_WIDTH'(bytes_q);
            len_q  <= len_q - 32'(bytes_q);
          end
`ifdef DMA_RD_RESP_CHECK_EN
          if ((m_axi.rresp != AXI_RESP_OKAY) || (m_axi.rlast != (beat_q == arlen_q)))
            error_q <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

`ifndef DMA_RD_RESP_CHECK_EN
  logic unused_resp;
  assign unused_resp = ^{m_axi.rresp, m_axi.rlast};
`endif

  assign m_axi.araddr  = araddr_q;
  assign m_axi.arlen   = arlen_q;
  assign m_axi.arsize  = AXI_SIZE_4B;
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arvalid = ar_valid;
  assign m_axi.rready  = r_ready;

  assign o_fifo_wdata = m_axi.rdata;
  assign o_fifo_wen   = r_hs;
  assign o_done       = done;
  assign o_error      = error_q;
endmodule

// File: doc/dma_read_engine.md
Name: dma_read_engine

Overview:
- AXI4-Full read master (MM2S). Reads a contiguous DDR region and pushes 32-bit words into a downstream FIFO that feeds the Gearbox toward the crypto/packet path.
- Mirror of the DMA write engine:
  - same CSR control style (start/base/len/done/error);
  - same burst-split rules: 4KB boundary, max 256 beats;
  - FIFO backpressure propagated to RREADY.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI and FIFO data width; beat = DATA_WIDTH/8 bytes.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_base_addr  in  ADDR_WIDTH  source DDR byte address; must be 64B aligned.
- i_total_len  in  32  bytes to read; must be multiple of 4 and nonzero.
- o_done  out  1  one-cycle completion pulse.
- o_error  out  1  sticky error flag.
- o_fifo_wdata  out  DATA_WIDTH  word to FIFO.
- o_fifo_wen  out  1  FIFO write strobe.
- i_fifo_full  in  1  1 = FIFO cannot accept a word.
- m_axi_araddr  out  ADDR_WIDTH  burst start address.
- m_axi_arlen  out  8  beats-1.
- m_axi_arsize  out  3  fixed 3'b010.
- m_axi_arburst  out  2  fixed INCR 2'b01.
- m_axi_arvalid  out  1  AR valid.
- m_axi_arready  in  1  AR ready.
- m_axi_rdata  in  DATA_WIDTH  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rlast  in  1  last beat.
- m_axi_rvalid  in  1  R valid.
- m_axi_rready  out  1  R ready.

Behaviour:
- Reset: state IDLE; addr/len/beat counter 0. Outputs o_done, o_error, o_fifo_wen, m_axi_arvalid, m_axi_rready all 0; araddr/arlen 0.
- States: IDLE, CALC, AR_HANDSHAKE, R_BURST, DONE.
- IDLE:
  - On i_start with a bad argument (base[5:0]!=0, len[1:0]!=0, or len==0): set o_error=1 and stay in IDLE.
  - Otherwise: clear o_error, latch addr/len, go to CALC.
  - i_start in any other state is ignored.
- CALC: one cycle, then AR_HANDSHAKE. Burst bytes = min(len_left, 4096 - addr[11:0], 1024); arlen = bytes/4 - 1.
- AR_HANDSHAKE:
  - arvalid=1; araddr/arlen stay stable until arready.
  - On the handshake: beat counter cleared, go to R_BURST.
- R_BURST:
  - rready = !i_fifo_full.
  - o_fifo_wen = rvalid && rready; o_fifo_wdata = rdata, combinational (zero added latency).
  - Each handshake increments the beat counter.
  - Burst ends on the handshake where beat counter == arlen. On that cycle: addr += bytes, len_left -= bytes. Next state is DONE if len_left == bytes, else CALC.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- Full FIFO: rready drops in the same cycle; no word is lost or duplicated; R beats are held by the slave.
- Only one outstanding burst at a time.
- 4KB edge: e.g. addr 0x0FC0, len 256 → burst 1 = 64B (arlen 15) to 0x0FC0; burst 2 = 192B (arlen 47) at 0x1000.
- Reset mid-burst: returns immediately to IDLE with no done pulse. The AXI slave is assumed reset by the same rst_n.

Optional Feature:
- DMA_RD_RESP_CHECK_EN defined:
  - rresp != OKAY on any beat sets o_error (sticky). The transfer still completes and o_done still pulses.
  - rlast disagreeing with beat counter == arlen also sets o_error; the counter remains authoritative for burst end.
- Not defined: rresp and rlast are ignored; o_error reflects only argument checks.

Decomposition:
- Shared package dma_pkg, used by both read and write engines:
  - state enum;
  - AXI constants: AXI_BURST_INCR, AXI_SIZE_4B, AXI_RESP_OKAY;
  - DMA_4K_BYTES = 4096, DMA_MAX_BURST_BYTES = 1024.
- Sub-module dma_burst_calc (combinational min-3 split: addr, len_left → bytes, len_minus1), shared with the write engine.

Test Plan:
- Base 0x1000_0000, len 64, slave always ready → one AR with arlen 15; 16 fifo writes in order; o_done pulse; no error.
- Base 0x0000_0FC0, len 256 → AR#1 addr 0x0FC0 arlen 15; AR#2 addr 0x1000 arlen 47; 64 words total; single o_done.
- Base 0x2000, len 4096 → four ARs at 0x2000/0x2400/0x2800/0x2C00, each arlen 255.
- i_fifo_full toggled every other cycle during len 32 → rready mirrors !full; exactly 8 writes; data order preserved.
- Bad arguments: base 0x1004 → o_error=1, no AR, state IDLE. Then a valid start with base 0x1000 → o_error clears.
- With DMA_RD_RESP_CHECK_EN: rresp=SLVERR on beat 3 of 16 → o_error=1 and o_done still pulses. Without the macro: o_error stays 0.
